vend_controller: RTL

- Top-level sequencer for the coin-operated vending path.
- Accumulates credit from nickel, dime and quarter coin pulses.
- On a product select with sufficient credit, runs a request/acknowledge handshake with the dispenser mechanism, then returns any excess credit as a train of nickel pulses.
- Also handles cancel and inactivity-timeout refunds, and rejects coins it cannot accept.

---
 rtl/vend_controller.sv | 108 ++++++++++
 1 files changed

// File: rtl/vend_controller.sv
// vend_controller: coin credit accumulator with dispense handshake, change return and refunds
module vend_controller #(
    parameter int PRICE      = 15,
    parameter int CREDIT_MAX = 95,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inN,
    input  logic       inD,
    input  logic       inQ,
    input  logic       sel,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       chg_nickel,
    output logic       coin_reject,
    output logic [6:0] credit,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    state_t          state_q, state_d;
    logic [6:0]      credit_q, credit_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            gap_q, gap_d;
    logic            disp_req_q, chg_q, chg_d, rej_q, rej_d, busy_q;
    logic            coin_any, coin_fits, accept;
    logic [7:0]      coin_val;

    assign coin_any  = inN | inD | inQ;
    assign coin_val  = inQ ? 8'd25 : inD ? 8'd10 : 8'd5;
    assign coin_fits = ({1'b0, credit_q} + coin_val) <= 8'(CREDIT_MAX);
    // a cancel in CREDIT wins over a coin, so that coin is bounced rather than credited
    assign accept    = (state_q == IDLE || (state_q == CREDIT && !cancel))
                       && $onehot({inN, inD, inQ}) && coin_fits;

    assign disp_req    = disp_req_q;
    assign chg_nickel  = chg_q;
    assign coin_reject = rej_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

    // next-state, credit bookkeeping, idle timer and change pulse/gap sequencing
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = '0;
        gap_d    = 1'b0;
        chg_d    = 1'b0;
        rej_d    = coin_any && !accept;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    credit_d = credit_q + coin_val[6:0];
                    state_d  = CREDIT;
                end
            end
            CREDIT: begin
                if (cancel) state_d = CHANGE;
                else if (coin_any) credit_d = accept ? credit_q + coin_val[6:0] : credit_q;
                else if (sel) state_d = (credit_q >= 7'(PRICE)) ? DISPENSE : CREDIT;
                else if (timer_q == TW'(TIMEOUT - 1)) state_d = CHANGE;
                else timer_d = timer_q + 1'b1;
            end
            DISPENSE: begin
                if (disp_ack) begin
                    credit_d = credit_q - 7'(PRICE);
                    state_d  = (credit_q == 7'(PRICE)) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                if (gap_q) begin
                    state_d = (credit_q == 7'd0) ? IDLE : CHANGE;
                end else begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - 7'd5;
                    gap_d    = 1'b1;
                end
            end
        endcase
    end

    // state and registered outputs; reset drops everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            timer_q    <= '0;
            gap_q      <= 1'b0;
            disp_req_q <= 1'b0;
            chg_q      <= 1'b0;
            rej_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            disp_req_q <= state_d == DISPENSE;
            chg_q      <= chg_d;
            rej_q      <= rej_d;
            busy_q     <= state_d == DISPENSE || state_d == CHANGE;
        end
    end
endmodule
